// File: rtl/hit_judge.sv
`timescale 1ns/1ps
// hit_judge -- rhythm-game hit judgment for one note stream.
//
// Watches the song's note code on each beat tick, opens a judgment window
// when a new note lands, and grades the player's button press as PERFECT,
// GOOD or miss. Keeps a saturating score and combo, and flashes a grade
// colour on the full-colour LED.
//
// Ports:
//   CLK     in   system clock
//   RESETN  in   asynchronous reset, active-high (despite the name)
//   tick    in   one-CLK beat strobe
//   en      in   scoring enable; a rising edge starts a fresh song
//   note    in   [3:0] note code, 1..8 = lane 0..7, anything else = rest
//   key     in   [7:0] raw asynchronous push-button levels
//   score   out  [9:0] points, saturating at 999
//   combo   out  [6:0] consecutive hits, saturating at 127
//   rgb     out  [5:0] {R,G,B} grade colour
//   hit_p   out  one-CLK pulse per judged hit
//   miss_p  out  one-CLK pulse per judged miss
//
// Build option: define COMBO_BONUS_EN to award one extra point for every hit
// judged while the combo is already at 10 or more.
module hit_judge #(
    parameter int WINDOW = 4,
    parameter int FLASH  = 8
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       tick,
    input  logic       en,
    input  logic [3:0] note,
    input  logic [7:0] key,
    output logic [9:0] score,
    output logic [6:0] combo,
    output logic [5:0] rgb,
    output logic       hit_p,
    output logic       miss_p
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [3:0] WIN_LAST   = 4'(WINDOW - 1);
    localparam logic [7:0] FLASH_INIT = 8'(FLASH);
    localparam logic [5:0] RGB_PERF   = 6'b001000;
    localparam logic [5:0] RGB_GOOD   = 6'b000010;
    localparam logic [5:0] RGB_MISS   = 6'b100000;

    state_t     state, state_next;
    logic [7:0] key_s1, key_s2, key_prev;
    logic [3:0] note_prev;
    logic       en_prev;
    logic [3:0] win_cnt, win_next;
    logic [2:0] target, target_next;
    logic [7:0] flash_cnt;

    logic [7:0] press;
    logic       note_valid, onset, en_rise;
    logic       target_hit, other_press, expire;
    logic [3:0] lane_full;
    logic       judge_hit, judge_miss, perfect;
    logic [1:0] pts;
    logic [9:0] score_sum, score_sat;

    // Press detection compares the synchronized level against its own
    // previous registered value, so a held button only counts once.
    assign press       = key_s2 & ~key_prev;
    assign note_valid  = (note >= 4'd1) && (note <= 4'd8);
    assign onset       = tick && note_valid && (note != note_prev);
    assign en_rise     = en && !en_prev;
    assign lane_full   = note - 4'd1;
    assign target_hit  = press[target];
    assign other_press = (|press) && !target_hit;
    assign expire      = tick && (win_cnt == WIN_LAST);

    // Synchronizer, edge history, previous note and enable history.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            key_s1    <= '0;
            key_s2    <= '0;
            key_prev  <= '0;
            note_prev <= '0;
            en_prev   <= 1'b0;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            en_prev  <= en;
            if (tick) begin
                note_prev <= note;
            end
        end
    end

    // Judgment state register with its window counter and target lane.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state   <= IDLE;
            win_cnt <= '0;
            target  <= '0;
        end else begin
            state   <= state_next;
            win_cnt <= win_next;
            target  <= target_next;
        end
    end

    // Next-state and judgment decode. A hit on the pending note takes
    // priority over any miss cause; a fresh onset in the same cycle always
    // re-arms the window for the new note after the old one is settled.
    always_comb begin
        state_next  = state;
        win_next    = win_cnt;
        target_next = target;
        judge_hit   = 1'b0;
        judge_miss  = 1'b0;
        perfect     = 1'b0;
        if (!en || en_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (onset) begin
                        state_next  = WAIT;
                        win_next    = '0;
                        target_next = lane_full[2:0];
                    end
                end
                WAIT: begin
                    if (target_hit) begin
                        judge_hit  = 1'b1;
                        perfect    = (win_cnt == 4'd0);
                        state_next = IDLE;
                    end else if (other_press || onset || expire) begin
                        judge_miss = 1'b1;
                        state_next = IDLE;
                    end else if (tick) begin
                        win_next = win_cnt + 4'd1;
                    end
                    if (onset) begin
                        state_next  = WAIT;
                        win_next    = '0;
                        target_next = lane_full[2:0];
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Points for the current hit, including the optional long-combo bonus.
    // The sum cannot exceed 1002, so 10 bits hold it before saturation.
    always_comb begin
        pts = perfect ? 2'd2 : 2'd1;
`ifdef COMBO_BONUS_EN
        if (combo >= 7'd10) begin
            pts = pts + 2'd1;
        end
`endif
        score_sum = score + 10'(pts);
        score_sat = (score_sum > 10'd999) ? 10'd999 : score_sum;
    end

    // Score, combo, pulses and the LED flash. The flash counter runs on
    // beat ticks and blanks the LED when it expires; a new judgment
    // restarts it.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            score     <= '0;
            combo     <= '0;
            rgb       <= '0;
            hit_p     <= 1'b0;
            miss_p    <= 1'b0;
            flash_cnt <= '0;
        end else begin
            hit_p  <= judge_hit;
            miss_p <= judge_miss;
            if (en_rise) begin
                score     <= '0;
                combo     <= '0;
                rgb       <= '0;
                flash_cnt <= '0;
            end else if (judge_hit) begin
                score     <= score_sat;
                combo     <= (combo == 7'd127) ? 7'd127 : combo + 7'd1;
                rgb       <= perfect ? RGB_PERF : RGB_GOOD;
                flash_cnt <= FLASH_INIT;
            end else if (judge_miss) begin
                combo     <= '0;
                rgb       <= RGB_MISS;
                flash_cnt <= FLASH_INIT;
            end else if (tick && (flash_cnt != 8'd0)) begin
                flash_cnt <= flash_cnt - 8'd1;
                if (flash_cnt == 8'd1) begin
                    rgb <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
`timescale 1ns/1ps
// tb_hit_judge -- scoreboard bench for hit_judge (WINDOW=4, FLASH=8).
//
// Directed stimulus pushes the expected judgment into a queue; a monitor
// pops and compares whenever the DUT pulses hit_p or miss_p. A pulse with
// nothing queued is an error, as is anything left queued at the end.
// Expected bonus scoring follows COMBO_BONUS_EN when it is defined.
module tb_hit_judge;

    localparam int WINDOW = 4;
    localparam int FLASH  = 8;
    localparam int RGB_PERF = 8;
    localparam int RGB_GOOD = 2;
    localparam int RGB_MISS = 32;
`ifdef COMBO_BONUS_EN
    localparam int SCORE_AFTER_11 = 23;
`else
    localparam int SCORE_AFTER_11 = 22;
`endif

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       tick;
    logic       en;
    logic [3:0] note;
    logic [7:0] key;
    logic [9:0] score;
    logic [6:0] combo;
    logic [5:0] rgb;
    logic       hit_p;
    logic       miss_p;

    typedef struct {
        logic       hit;
        logic       miss;
        int         score;
        int         combo;
        int         rgb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_score = 0;
    int   m_combo = 0;

    hit_judge #(.WINDOW(WINDOW), .FLASH(FLASH)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .tick   (tick),
        .en     (en),
        .note   (note),
        .key    (key),
        .score  (score),
        .combo  (combo),
        .rgb    (rgb),
        .hit_p  (hit_p),
        .miss_p (miss_p)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // One beat: note presented with tick high across a single rising edge.
    task automatic applyStimulus(input logic [3:0] n);
        @(negedge CLK);
        note = n;
        tick = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
    endtask

    // Press then release, leaving time for the synchronizer both ways.
    task automatic pressKey(input logic [7:0] k);
        @(negedge CLK);
        key = k;
        repeat (4) @(negedge CLK);
        key = 8'h00;
        repeat (4) @(negedge CLK);
    endtask

    task automatic expectHit(input bit is_perfect);
        exp_t e;
        int   p;
        p = is_perfect ? 2 : 1;
`ifdef COMBO_BONUS_EN
        if (m_combo >= 10) p = p + 1;
`endif
        m_score = (m_score + p > 999) ? 999 : m_score + p;
        m_combo = (m_combo == 127) ? 127 : m_combo + 1;
        e.hit = 1'b1; e.miss = 1'b0; e.score = m_score; e.combo = m_combo;
        e.rgb = is_perfect ? RGB_PERF : RGB_GOOD;
        sb.push_back(e);
    endtask

    task automatic expectMiss();
        exp_t e;
        m_combo = 0;
        e.hit = 1'b0; e.miss = 1'b1; e.score = m_score; e.combo = 0;
        e.rgb = RGB_MISS;
        sb.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_score"}, int'(score), 0);
        checkOutput({tag, "_combo"}, int'(combo), 0);
        checkOutput({tag, "_rgb"}, int'(rgb), 0);
        checkOutput({tag, "_hit_p"}, int'(hit_p), 0);
        checkOutput({tag, "_miss_p"}, int'(miss_p), 0);
    endtask

    // Monitor: every judgment pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (hit_p || miss_p) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: actual hit_p=%0b miss_p=%0b required no pulse",
                         hit_p, miss_p);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_hit_p", int'(hit_p), int'(mon_e.hit));
                checkOutput("sb_miss_p", int'(miss_p), int'(mon_e.miss));
                checkOutput("sb_score", int'(score), mon_e.score);
                checkOutput("sb_combo", int'(combo), mon_e.combo);
                checkOutput("sb_rgb", int'(rgb), mon_e.rgb);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] n;
        RESETN = 1'b1;
        tick   = 1'b0;
        en     = 1'b0;
        note   = 4'd0;
        key    = 8'h00;
        repeat (3) @(negedge CLK);
        checkAllZero("reset");
        RESETN = 1'b0;
        @(negedge CLK);
        en = 1'b1;
        repeat (2) @(negedge CLK);

        $display("[TB] immediate PERFECT on lane 2");
        applyStimulus(4'd3);
        expectHit(1'b1);
        pressKey(8'h04);
        checkOutput("perfect_score", int'(score), 2);
        checkOutput("perfect_combo", int'(combo), 1);
        checkOutput("perfect_rgb", int'(rgb), RGB_PERF);

        $display("[TB] GOOD after two ticks, then flash decay");
        applyStimulus(4'd0);
        applyStimulus(4'd3);
        applyStimulus(4'd3);
        applyStimulus(4'd3);
        expectHit(1'b0);
        pressKey(8'h04);
        checkOutput("good_score", int'(score), 3);
        checkOutput("good_rgb", int'(rgb), RGB_GOOD);
        repeat (7) applyStimulus(4'd3);
        checkOutput("flash_held_7", int'(rgb), RGB_GOOD);
        applyStimulus(4'd3);
        checkOutput("flash_off_8", int'(rgb), 0);

        $display("[TB] window expiry on lane 5");
        applyStimulus(4'd6);
        repeat (3) applyStimulus(4'd6);
        expectMiss();
        applyStimulus(4'd6);
        checkOutput("expiry_combo", int'(combo), 0);
        checkOutput("expiry_rgb", int'(rgb), RGB_MISS);

        $display("[TB] wrong lane clears combo, IDLE press ignored");
        applyStimulus(4'd1);
        expectHit(1'b1);
        pressKey(8'h01);
        applyStimulus(4'd2);
        expectMiss();
        pressKey(8'h40);
        pressKey(8'h01);
        checkOutput("wrong_lane_score", int'(score), 5);
        checkOutput("wrong_lane_combo", int'(combo), 0);

        $display("[TB] onset while waiting misses the pending note");
        applyStimulus(4'd4);
        expectMiss();
        applyStimulus(4'd5);
        expectHit(1'b1);
        pressKey(8'h10);
        checkOutput("reonset_score", int'(score), 7);

        $display("[TB] hit and window expiry in the same cycle");
        applyStimulus(4'd7);
        repeat (3) applyStimulus(4'd7);
        expectHit(1'b0);
        @(negedge CLK);
        key = 8'h40;
        @(negedge CLK);
        @(negedge CLK);
        tick = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
        @(negedge CLK);
        key = 8'h00;
        repeat (4) @(negedge CLK);
        checkOutput("tie_score", int'(score), 8);
        checkOutput("tie_combo", int'(combo), 2);

        $display("[TB] enable low holds, enable rise clears");
        @(negedge CLK);
        en = 1'b0;
        applyStimulus(4'd8);
        pressKey(8'h80);
        checkOutput("en_low_score", int'(score), 8);
        checkOutput("en_low_combo", int'(combo), 2);
        en = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("en_rise_score", int'(score), 0);
        checkOutput("en_rise_combo", int'(combo), 0);
        checkOutput("en_rise_rgb", int'(rgb), 0);
        m_score = 0;
        m_combo = 0;

        $display("[TB] 500 PERFECT hits toward saturation");
        for (int i = 0; i < 500; i++) begin
            n = (i % 2 == 0) ? 4'd1 : 4'd2;
            applyStimulus(n);
            expectHit(1'b1);
            pressKey((n == 4'd1) ? 8'h01 : 8'h02);
            if (i == 10) checkOutput("score_after_11", int'(score), SCORE_AFTER_11);
        end
        checkOutput("sat_score", int'(score), 999);
        checkOutput("sat_combo", int'(combo), 127);

        $display("[TB] reset in the middle of a window");
        applyStimulus(4'd1);
        @(negedge CLK);
        RESETN = 1'b1;
        #1;
        checkAllZero("midreset");
        repeat (2) @(negedge CLK);
        RESETN = 1'b0;
        pressKey(8'h01);
        checkOutput("post_reset_score", int'(score), 0);
        checkOutput("post_reset_combo", int'(combo), 0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
